// File: rtl/cordic_sched.sv
// Round-robin front end for a shared, fully pipelined CORDIC: grants one of four
// requesters per clock and tags each operation so its result returns with its requester id.
`timescale 1ns/1ps
module cordic_sched #(
  parameter int XY_SZ = 16,
  parameter int LAT   = 16,
  parameter int NREQ  = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    pause,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*32-1:0]      req_angle,
  input  logic [NREQ*XY_SZ-1:0]   req_x,
  input  logic [NREQ*XY_SZ-1:0]   req_y,
  output logic [31:0]             c_angle,
  output logic [XY_SZ-1:0]        c_xin,
  output logic [XY_SZ-1:0]        c_yin,
  input  logic [XY_SZ:0]          c_xout,
  input  logic [XY_SZ:0]          c_yout,
  output logic                    res_valid,
  output logic [1:0]              res_id,
  output logic [XY_SZ:0]          res_x,
  output logic [XY_SZ:0]          res_y,
  output logic [4:0]              inflight,
  output logic                    busy
);

  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       gntIdx, cand;
  logic             accept;
  logic [31:0]      c_angle_q;
  logic [XY_SZ-1:0] c_xin_q, c_yin_q;
  logic [LAT:0]     tagValid_q;
  logic [1:0]       tagId_q [LAT+1];
  logic [4:0]       inflight_q, inflight_d;

  // Search starts at ptr and wraps; the first requester found wins the slot.
  always_comb begin
    accept = 1'b0;
    gntIdx = ptr_q;
    cand   = ptr_q;
    for (int k = 0; k < NREQ; k++) begin
      cand = ptr_q + 2'(k);
      if (!accept && !pause && req_valid[cand]) begin
        accept = 1'b1;
        gntIdx = cand;
      end
    end
    req_ready = '0;
    if (accept) req_ready[gntIdx] = 1'b1;
  end

  always_comb begin
    ptr_d      = accept ? gntIdx + 2'd1 : ptr_q;
    inflight_d = inflight_q;
    case ({accept, tagValid_q[LAT]})
      2'b10:   inflight_d = inflight_q + 5'd1;
      2'b01:   inflight_d = inflight_q - 5'd1;
      default: inflight_d = inflight_q;
    endcase
  end

  // The tag line runs in lockstep with the CORDIC pipeline, so it never stalls.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q      <= 2'd0;
      tagValid_q <= '0;
      for (int k = 0; k <= LAT; k++) tagId_q[k] <= 2'd0;
      c_angle_q  <= '0;
      c_xin_q    <= '0;
      c_yin_q    <= '0;
      inflight_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      inflight_q <= inflight_d;
      tagValid_q <= {tagValid_q[LAT-1:0], accept};
      tagId_q[0] <= gntIdx;
      for (int k = 1; k <= LAT; k++) tagId_q[k] <= tagId_q[k-1];
      if (accept) begin
        c_angle_q <= req_angle[32*gntIdx +: 32];
        c_xin_q   <= req_x[XY_SZ*gntIdx +: XY_SZ];
        c_yin_q   <= req_y[XY_SZ*gntIdx +: XY_SZ];
      end
    end
  end

  assign c_angle   = c_angle_q;
  assign c_xin     = c_xin_q;
  assign c_yin     = c_yin_q;
  assign res_valid = tagValid_q[LAT];
  assign res_id    = tagId_q[LAT];
  assign res_x     = c_xout;
  assign res_y     = c_yout;
  assign inflight  = inflight_q;
  assign busy      = (inflight_q != 5'd0);

endmodule

// File: tb/tb_cordic_sched.sv
// Scoreboard bench for cordic_sched: a behavioural CORDIC sits on the c_* ports,
// grants are checked against hand-derived tables and results are matched in order.
`timescale 1ns/1ps
module tb_cordic_sched;

  localparam int XY  = 16;
  localparam int LAT = 16;
  localparam real KGAIN = 1.646760258;

  logic           clock;
  logic           reset_n;
  logic           pause;
  logic [3:0]     req_valid;
  logic [3:0]     req_ready;
  logic [127:0]   req_angle;
  logic [4*XY-1:0] req_x, req_y;
  logic [31:0]    c_angle;
  logic [XY-1:0]  c_xin, c_yin;
  logic [XY:0]    c_xout, c_yout;
  logic           res_valid;
  logic [1:0]     res_id;
  logic [XY:0]    res_x, res_y;
  logic [4:0]     inflight;
  logic           busy;

  typedef struct {
    logic [1:0]         id;
    logic signed [XY:0] x;
    logic signed [XY:0] y;
    int                 due;
    bit                 chk45;
  } exp_t;

  exp_t sb[$];
  int   vecs = 0;
  int   miss = 0;
  int   cyc  = 0;

  logic [31:0]        angT  [4] = '{32'h0000_0000, 32'h4000_0000, 32'h2000_0000, 32'hC000_0000};
  logic signed [15:0] xBase [4] = '{16'sd1000, 16'sd2000, 16'sd16384, -16'sd3000};
  logic signed [15:0] yBase [4] = '{16'sd0, 16'sd500, 16'sd0, 16'sd1500};

  logic signed [XY:0] pipeX [LAT];
  logic signed [XY:0] pipeY [LAT];

  cordic_sched #(.XY_SZ(XY), .LAT(LAT), .NREQ(4)) dut (
    .clock(clock), .reset_n(reset_n), .pause(pause),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_angle(req_angle), .req_x(req_x), .req_y(req_y),
    .c_angle(c_angle), .c_xin(c_xin), .c_yin(c_yin),
    .c_xout(c_xout), .c_yout(c_yout),
    .res_valid(res_valid), .res_id(res_id), .res_x(res_x), .res_y(res_y),
    .inflight(inflight), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Ideal rotation including the CORDIC gain, rounded to the result width.
  function automatic logic signed [XY:0] rotate(input logic [31:0] a, input logic signed [15:0] x,
                                                input logic signed [15:0] y, input bit wantY);
    real th, r, xr, yr;
    th = real'(a) * 6.283185307179586 / 4294967296.0;
    xr = real'(x);
    yr = real'(y);
    if (wantY) r = KGAIN * (xr * $sin(th) + yr * $cos(th));
    else       r = KGAIN * (xr * $cos(th) - yr * $sin(th));
    return 17'($rtoi(r + ((r >= 0.0) ? 0.5 : -0.5)));
  endfunction

  // Behavioural CORDIC: LAT clocks from the registered c_* operands to c_xout/c_yout.
  always @(posedge clock) begin
    pipeX[0] <= rotate(c_angle, $signed(c_xin), $signed(c_yin), 1'b0);
    pipeY[0] <= rotate(c_angle, $signed(c_xin), $signed(c_yin), 1'b1);
    for (int k = 1; k < LAT; k++) begin
      pipeX[k] <= pipeX[k-1];
      pipeY[k] <= pipeY[k-1];
    end
  end
  assign c_xout = pipeX[LAT-1];
  assign c_yout = pipeY[LAT-1];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: every result strobe must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (reset_n && res_valid) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_res_valid", {31'd0, res_valid}, 32'd0);
      end else begin
        exp_t e;
        int   d;
        e = sb.pop_front();
        checkOutput("res_id", {30'd0, res_id}, {30'd0, e.id});
        checkOutput("res_x", $signed(res_x), e.x);
        checkOutput("res_y", $signed(res_y), e.y);
        checkOutput("res_cycle", cyc, e.due);
        if (e.chk45) begin
          d = int'($signed(res_x)) - 19079;
          checkOutput("res_x_45deg", {31'd0, (d >= -4 && d <= 4)}, 32'd1);
          d = int'($signed(res_y)) - 19079;
          checkOutput("res_y_45deg", {31'd0, (d >= -4 && d <= 4)}, 32'd1);
        end
      end
    end
  end

  task automatic applyStimulus(input logic [3:0] valid, input logic pauseVal,
                               input logic [3:0] expReady, input int expInflight);
    logic signed [15:0] xs [4];
    exp_t e;
    @(negedge clock);
    req_valid = valid;
    pause     = pauseVal;
    for (int i = 0; i < 4; i++) begin
      xs[i] = (i == 2) ? xBase[i] : xBase[i] + 16'(cyc % 64);
      req_angle[i*32 +: 32] = angT[i];
      req_x[i*XY +: XY]     = xs[i];
      req_y[i*XY +: XY]     = yBase[i];
    end
    #1;
    checkOutput("req_ready", {28'd0, req_ready}, {28'd0, expReady});
    if (expInflight >= 0) begin
      checkOutput("inflight", {27'd0, inflight}, 32'(expInflight));
      checkOutput("busy", {31'd0, busy}, {31'd0, (expInflight != 0)});
    end
    if (expReady != 4'd0) begin
      for (int i = 0; i < 4; i++) begin
        if (expReady[i]) begin
          e.id    = 2'(i);
          e.x     = rotate(angT[i], xs[i], yBase[i], 1'b0);
          e.y     = rotate(angT[i], xs[i], yBase[i], 1'b1);
          e.due   = cyc + LAT + 1;
          e.chk45 = (i == 2);
        end
      end
      sb.push_back(e);
    end
  endtask

  task automatic doReset();
    reset_n   = 1'b0;
    pause     = 1'b0;
    req_valid = 4'd0;
    sb.delete();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    #1;
    checkOutput("rst_req_ready", {28'd0, req_ready}, 32'd0);
    checkOutput("rst_res_valid", {31'd0, res_valid}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_inflight", {27'd0, inflight}, 32'd0);
    checkOutput("rst_c_angle", c_angle, 32'd0);
    checkOutput("rst_c_xin", {16'd0, c_xin}, 32'd0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(4'd0, 1'b0, 4'd0, -1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset_n = 1'b1; pause = 1'b0; req_valid = '0;
    req_angle = '0; req_x = '0; req_y = '0;
    #2;
    doReset();

    // single 45-degree op from requester 2
    applyStimulus(4'b0100, 1'b0, 4'b0100, 0);
    for (int k = 1; k <= 20; k++) applyStimulus(4'd0, 1'b0, 4'd0, (k <= 17) ? 1 : 0);

    // round robin with everyone requesting
    doReset();
    for (int k = 0; k < 8; k++) applyStimulus(4'b1111, 1'b0, 4'(1 << (k % 4)), k);
    idle(20);

    // fairness between two requesters
    doReset();
    for (int k = 0; k < 4; k++) applyStimulus(4'b1001, 1'b0, (k % 2) ? 4'b1000 : 4'b0001, -1);
    for (int k = 0; k < 4; k++) applyStimulus(4'b0110, 1'b0, (k % 2) ? 4'b0100 : 4'b0010, -1);
    idle(20);

    // saturation then drain
    doReset();
    for (int k = 0; k < 40; k++) applyStimulus(4'b1111, 1'b0, 4'(1 << (k % 4)), (k < 17) ? k : 17);
    for (int j = 0; j < 20; j++) applyStimulus(4'd0, 1'b0, 4'd0, (j < 17) ? 17 - j : 0);

    // pause while ops are in flight
    doReset();
    for (int k = 0; k < 3; k++) applyStimulus(4'b1111, 1'b0, 4'(1 << k), k);
    for (int k = 3; k < 25; k++) begin
      int r;
      r = (k - 17 < 0) ? 0 : ((k - 17 > 3) ? 3 : k - 17);
      applyStimulus(4'b1111, 1'b1, 4'd0, 3 - r);
    end
    applyStimulus(4'b1111, 1'b0, 4'b1000, 0);
    applyStimulus(4'b1111, 1'b0, 4'b0001, 1);
    idle(20);

    // reset with five ops outstanding
    doReset();
    for (int k = 0; k < 5; k++) applyStimulus(4'b1111, 1'b0, 4'(1 << (k % 4)), k);
    applyStimulus(4'd0, 1'b0, 4'd0, 5);
    applyStimulus(4'd0, 1'b0, 4'd0, 5);
    doReset();
    for (int k = 0; k < 25; k++) applyStimulus(4'd0, 1'b0, 4'd0, 0);
    applyStimulus(4'b1111, 1'b0, 4'b0001, 0);
    applyStimulus(4'b0110, 1'b0, 4'b0010, 1);
    idle(25);

    checkOutput("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule

// File: doc/cordic_sched.md
CORDIC_SCHED -- requirements
Module: cordic_sched

Interface
REQ-001 The block SHALL have parameter XY_SZ, default 16, giving the width of the X/Y inputs (results are XY_SZ+1 bits).
REQ-002 The block SHALL have parameter LAT, default 16, giving the attached CORDIC pipeline latency in clocks; it SHALL equal that instance's XY_SZ.
REQ-003 The block SHALL have parameter NREQ, fixed at 4, giving the number of requesters.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 Port clock  in  1  rising-edge clock.
REQ-006 Port reset_n  in  1  asynchronous active-low reset.
REQ-007 Port pause  in  1  when high, no new grants.
REQ-008 Port req_valid  in  4  per-requester request.
REQ-009 Port req_ready  out  4  one-hot grant.
REQ-010 Port req_angle  in  4*32  packed; requester i at [32i+31:32i]; full circle mapped to 0..2^32-1.
REQ-011 Port req_x / req_y  in  4*XY_SZ  packed signed operands.
REQ-012 Port c_angle  out  32  registered angle to the CORDIC.
REQ-013 Port c_xin / c_yin  out  XY_SZ  registered operands to the CORDIC.
REQ-014 Port c_xout / c_yout  in  XY_SZ+1  CORDIC results.
REQ-015 Port res_valid  out  1  result strobe.
REQ-016 Port res_id  out  2  requester index of the result.
REQ-017 Port res_x / res_y  out  XY_SZ+1  result data.
REQ-018 Port inflight  out  5  count of operations outstanding.
REQ-019 Port busy  out  1  high when inflight != 0.

Function
REQ-020 Arbitration SHALL be round-robin: the search starts at index ptr, and the first i with req_valid[i] in ptr, ptr+1, ..., ptr+3 (mod 4) is granted.
REQ-021 req_ready SHALL be combinational, with at most one bit high, and all zero when pause=1 or req_valid=0.
REQ-022 A request SHALL be accepted on a rising edge where req_valid[i]&req_ready[i]=1; at most one acceptance per cycle, so throughput is 1 op/clock.
REQ-023 On acceptance, ptr SHALL load (i+1) mod 4; otherwise ptr SHALL hold.
REQ-024 On acceptance, c_angle/c_xin/c_yin SHALL load requester i's operands on the same edge; otherwise they SHALL hold their values.
REQ-025 A tag shift register of LAT+1 entries {valid,id} SHALL shift every clock, with entry 0 loaded {accept, i}; there is no stall.
REQ-026 res_valid/res_id SHALL equal tag entry LAT, res_x=c_xout and res_y=c_yout (combinational pass-through).
REQ-027 Latency: a request accepted in cycle t SHALL produce res_valid in cycle t+LAT+1 (17 by default), in acceptance order.
REQ-028 Results SHALL have no backpressure: each res_valid lasts exactly 1 cycle and requesters must capture it.
REQ-029 res_x/res_y SHALL be don't-care while res_valid=0.
REQ-030 inflight SHALL increment on acceptance only, decrement on res_valid only, and hold when both or neither occur; its maximum is LAT+1=17, and it cannot overflow or underflow.
REQ-031 Operand reformatting SHALL NOT be done: angle and operands pass unchanged, and quadrant pre-rotation is the CORDIC's job.
REQ-032 A requester dropping req_valid without a grant SHALL lose nothing; the request is simply not accepted.
REQ-033 If pause is asserted mid-stream, in-flight operations SHALL still complete and deliver results.

Reset
REQ-034 On reset_n low, asynchronously: ptr=0, all tag entries invalid, c_angle/c_xin/c_yin=0, inflight=0.
REQ-035 As a result, res_valid=0, busy=0 and req_ready is driven only by arbitration.
REQ-036 On reset mid-operation, all outstanding results SHALL be discarded: residual CORDIC contents never raise res_valid.
REQ-037 The first grant after reset_n rises SHALL follow ptr=0.

Verification
REQ-038 Single op: requester 2 sends angle=0x2000_0000 (45 deg), x=0x4000, y=0 -> after 17 cycles, one res_valid with res_id=2, res_x ≈ res_y ≈ 19079 (±4 LSB), inflight back to 0.
REQ-039 Round-robin: req_valid=4'b1111 held for 8 cycles after reset -> grants 0,1,2,3,0,1,2,3; res_id follows the same sequence starting 17 cycles later, with back-to-back res_valid.
REQ-040 Fairness: req_valid=4'b1001 held -> grants alternate 0,3,0,3; 4'b0110 -> grants alternate 1,2.
REQ-041 Saturation: continuous requests for 40 cycles -> inflight ramps 1..17, then holds at 17 with simultaneous issue/retire; after requests stop it drains to 0 and busy falls.
REQ-042 Pause: pause=1 with all requests valid -> req_ready=0 and no new tags; ops already issued still return at their scheduled cycles.
REQ-043 Reset mid-op: 5 ops issued, reset_n pulsed low 2 cycles later -> res_valid never rises for them, inflight=0, and the next grant goes to the lowest valid index.
